// File: rtl/bgm_sequencer.sv
// Background-music sequencer: fetches 12-bit note words from the buzzer ROM,
// times each note in beats and drives a square wave on the buzzer pin.
module bgm_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 12,
  parameter int TICK_DIV   = 500,
  parameter int BEAT_DIV   = 12_500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  play_i,
  input  logic                  restart_i,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  buzzer_o,
  output logic                  playing_o,
  output logic                  wrap_o
);

  localparam int BW = $clog2(BEAT_DIV) + 4;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [BW-1:0] BEAT_DIV_W = BW'(BEAT_DIV);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY
  } state_e;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [3:0]            beats_q,    beats_d;
  logic [7:0]            pitch_q,    pitch_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [7:0]            half_cnt_q, half_cnt_d;
  logic                  buzzer_q,   buzzer_d;
  logic                  wrap_q,     wrap_d;
  logic                  lock_q,     lock_d;

  logic          run;
  logic          tick;
  logic          note_done;
  logic [BW-1:0] note_len;
  logic [3:0]    rom_beats;
  logic [7:0]    rom_pitch;

  assign rom_beats = rom_data_i[11:8];
  assign rom_pitch = rom_data_i[7:0];

  // Every counter advances only on unpaused PLAY cycles, so a pause freezes the note in place.
  assign run       = (state_q == S_PLAY) && play_i;
  assign tick      = run && (tick_cnt_q == TICK_LAST);
  assign note_len  = BW'(beats_q) * BEAT_DIV_W;
  assign note_done = run && (beat_cnt_q == note_len - BW'(1));

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a signal unassigned (no latches).
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    pitch_d    = pitch_q;
    beat_cnt_d = beat_cnt_q;
    tick_cnt_d = tick_cnt_q;
    half_cnt_d = half_cnt_q;
    buzzer_d   = buzzer_q;
    wrap_d     = 1'b0;
    lock_d     = lock_q;

    unique case (state_q)
      S_IDLE: begin
        if (play_i && !lock_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        if (rom_beats != 4'd0) begin
          beats_d    = rom_beats;
          pitch_d    = rom_pitch;
          beat_cnt_d = '0;
          tick_cnt_d = '0;
          half_cnt_d = '0;
          buzzer_d   = 1'b0;
          state_d    = S_PLAY;
        end else if (addr_q != '0) begin
          addr_d  = '0;
          wrap_d  = 1'b1;
          state_d = S_FETCH;
        end else begin
          // Empty song: park in IDLE until a restart clears the lockout.
          lock_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        if (run) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
          if (tick && pitch_q != 8'd0) begin
            if (half_cnt_q == pitch_q - 8'd1) begin
              half_cnt_d = '0;
              buzzer_d   = ~buzzer_q;
            end else begin
              half_cnt_d = half_cnt_q + 8'd1;
            end
          end
          if (note_done) begin
            addr_d     = addr_q + ADDR_WIDTH'(1);
            wrap_d     = (addr_q == '1);
            beat_cnt_d = '0;
            tick_cnt_d = '0;
            half_cnt_d = '0;
            buzzer_d   = 1'b0;
            state_d    = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (restart_i) begin
      addr_d     = '0;
      beat_cnt_d = '0;
      tick_cnt_d = '0;
      half_cnt_d = '0;
      buzzer_d   = 1'b0;
      wrap_d     = 1'b0;
      lock_d     = 1'b0;
      state_d    = play_i ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      pitch_q    <= '0;
      beat_cnt_q <= '0;
      tick_cnt_q <= '0;
      half_cnt_q <= '0;
      buzzer_q   <= 1'b0;
      wrap_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      pitch_q    <= pitch_d;
      beat_cnt_q <= beat_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      half_cnt_q <= half_cnt_d;
      buzzer_q   <= buzzer_d;
      wrap_q     <= wrap_d;
      lock_q     <= lock_d;
    end
  end

  assign rom_en_o   = (state_q == S_FETCH);
  assign rom_addr_o = addr_q;
  assign playing_o  = run;
  assign buzzer_o   = buzzer_q & run;
  assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_bgm_sequencer.sv
// Self-checking bench for bgm_sequencer: a behavioural 1-cycle ROM, a fetch
// scoreboard (address + wrap per FETCH) and per-feature timing checks.
module tb_bgm_sequencer;

  localparam int AW = 4;
  localparam int DW = 12;

  logic          clk;
  logic          rst_n;
  logic          play_i;
  logic          restart_i;
  logic          rom_en_o;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_data_i;
  logic          buzzer_o;
  logic          playing_o;
  logic          wrap_o;

  bgm_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TICK_DIV  (2),
    .BEAT_DIV  (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .play_i    (play_i),
    .restart_i (restart_i),
    .rom_en_o  (rom_en_o),
    .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i),
    .buzzer_o  (buzzer_o),
    .playing_o (playing_o),
    .wrap_o    (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rom [16];
  always @(posedge clk) if (rom_en_o) rom_data_i <= rom[rom_addr_o];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wrap;
  } fetch_t;

  fetch_t exp_q[$];
  bit     sb_on;
  int     checks;
  int     errors;

  // One clock; sample #1 after the edge and score any FETCH/wrap cycle.
  task automatic cyc();
    fetch_t e;
    @(posedge clk);
    #1;
    if (sb_on && (rom_en_o === 1'b1 || wrap_o === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected en=%b addr=%0d wrap=%b", rom_en_o, rom_addr_o, wrap_o);
      end else begin
        e = exp_q.pop_front();
        if (rom_en_o !== 1'b1 || rom_addr_o !== e.addr || wrap_o !== e.wrap) begin
          errors++;
          $display("FAIL fetch got en=%b addr=%0d wrap=%b want en=1 addr=%0d wrap=%b",
                   rom_en_o, rom_addr_o, wrap_o, e.addr, e.wrap);
        end
      end
    end
  endtask

  task automatic pulse_restart();
    restart_i = 1'b1;
    cyc();
    restart_i = 1'b0;
  endtask

  task automatic park_idle();
    sb_on  = 1'b0;
    play_i = 1'b0;
    pulse_restart();
    exp_q.delete();
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d after %0d cycles want 0", name, exp_q.size(), n);
    end
    exp_q.delete();
  endtask

  // Cycles until playing_o is seen high; -1 if the budget runs out.
  task automatic wait_play(input int budget, output int lat);
    lat = 0;
    while (playing_o !== 1'b1 && lat < budget) begin
      cyc();
      lat++;
    end
    if (playing_o !== 1'b1) lat = -1;
  endtask

  // From the first PLAY sample, measure note length and count buzzer errors
  // against a square wave of the given half-period (0 = rest).
  task automatic measure_note(input int half, output int len, output int bad);
    logic exp_b;
    len = 0;
    bad = 0;
    while (playing_o === 1'b1 && len < 1000) begin
      exp_b = (half == 0) ? 1'b0 : 1'((len / half) % 2);
      if (buzzer_o !== exp_b) bad++;
      len++;
      cyc();
    end
  endtask

  task automatic test_reset();
    int en_seen;
    rst_n = 1'b0; play_i = 1'b0; restart_i = 1'b0;
    #23;
    checks++;
    if ({rom_en_o, rom_addr_o, buzzer_o, playing_o, wrap_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b addr=%0d buz=%b ply=%b wrap=%b want all 0",
               rom_en_o, rom_addr_o, buzzer_o, playing_o, wrap_o);
    end
    rst_n = 1'b1;
    en_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (rom_en_o !== 1'b0 || playing_o !== 1'b0) en_seen++;
    end
    checks++;
    if (en_seen != 0) begin
      errors++;
      $display("FAIL idle_hold active_cycles=%0d want 0", en_seen);
    end
  endtask

  task automatic test_basic_note();
    int lat, len, bad;
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
    rom[0] = 12'h203;
    park_idle();
    exp_q.push_back('{addr: 4'd0, wrap: 1'b0});
    exp_q.push_back('{addr: 4'd1, wrap: 1'b0});
    exp_q.push_back('{addr: 4'd0, wrap: 1'b1});
    sb_on  = 1'b1;
    play_i = 1'b1;
    wait_play(20, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL first_note_latency got %0d want 3", lat);
    end
    measure_note(6, len, bad);
    checks++;
    if (len != 40) begin
      errors++;
      $display("FAIL basic_note_len got %0d want 40", len);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_buzzer_wave bad_cycles=%0d want 0", bad);
    end
    drain(20, "basic");
  endtask

  task automatic test_rest();
    int lat, len, bad;
    rom[0] = 12'h100;
    rom[1] = 12'h000;
    park_idle();
    exp_q.push_back('{addr: 4'd0, wrap: 1'b0});
    exp_q.push_back('{addr: 4'd1, wrap: 1'b0});
    exp_q.push_back('{addr: 4'd0, wrap: 1'b1});
    sb_on  = 1'b1;
    play_i = 1'b1;
    wait_play(20, lat);
    measure_note(0, len, bad);
    checks++;
    if (len != 20 || bad != 0) begin
      errors++;
      $display("FAIL rest_note len=%0d buzzer_high=%0d want len=20 buzzer_high=0", len, bad);
    end
    drain(20, "rest");
  endtask

  task automatic test_pause();
    int   lat, bad_b, bad_p;
    logic exp_b, exp_p;
    rom[0] = 12'h203;
    rom[1] = 12'h000;
    park_idle();
    exp_q.push_back('{addr: 4'd0, wrap: 1'b0});
    exp_q.push_back('{addr: 4'd1, wrap: 1'b0});
    sb_on  = 1'b1;
    play_i = 1'b1;
    wait_play(20, lat);
    bad_b = 0;
    bad_p = 0;
    for (int w = 0; w < 55; w++) begin
      exp_p  = !(w >= 10 && w < 25);
      play_i = exp_p;
      #1;
      if (w < 10)      exp_b = 1'((w / 6) % 2);
      else if (w < 25) exp_b = 1'b0;
      else             exp_b = 1'(((w - 15) / 6) % 2);
      if (buzzer_o !== exp_b) bad_b++;
      if (playing_o !== exp_p) bad_p++;
      cyc();
    end
    checks++;
    if (bad_b != 0) begin
      errors++;
      $display("FAIL pause_buzzer bad_cycles=%0d want 0", bad_b);
    end
    checks++;
    if (bad_p != 0) begin
      errors++;
      $display("FAIL pause_playing bad_cycles=%0d want 0", bad_p);
    end
    checks++;
    if (rom_en_o !== 1'b1 || playing_o !== 1'b0) begin
      errors++;
      $display("FAIL pause_note_end at cycle 55 en=%b ply=%b want en=1 ply=0", rom_en_o, playing_o);
    end
    exp_q.push_back('{addr: 4'd0, wrap: 1'b1});
    drain(20, "pause");
  endtask

  task automatic test_full_wrap();
    int lat, len, bad, gap;
    for (int i = 0; i < 16; i++) rom[i] = 12'h101;
    park_idle();
    for (int i = 0; i < 16; i++) exp_q.push_back('{addr: AW'(i), wrap: 1'b0});
    exp_q.push_back('{addr: 4'd0, wrap: 1'b1});
    sb_on  = 1'b1;
    play_i = 1'b1;
    wait_play(20, lat);
    measure_note(2, len, bad);
    checks++;
    if (len != 20 || bad != 0) begin
      errors++;
      $display("FAIL wrap_first_note len=%0d bad=%0d want len=20 bad=0", len, bad);
    end
    gap = 0;
    while (playing_o !== 1'b1 && gap < 10) begin
      if (buzzer_o !== 1'b0) bad++;
      gap++;
      cyc();
    end
    checks++;
    if (gap != 2 || bad != 0) begin
      errors++;
      $display("FAIL note_gap got %0d cycles buzz=%0d want 2 cycles buzz=0", gap, bad);
    end
    drain(600, "full_wrap");
  endtask

  task automatic test_restart();
    int n;
    park_idle();
    play_i = 1'b1;
    pulse_restart();
    n = 0;
    while (!(rom_addr_o === 4'd5 && playing_o === 1'b1) && n < 500) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL restart_reach_addr5 timeout addr=%0d", rom_addr_o);
    end
    for (int i = 0; i < 3; i++) cyc();
    exp_q.push_back('{addr: 4'd0, wrap: 1'b0});
    sb_on = 1'b1;
    pulse_restart();
    checks++;
    if (rom_addr_o !== 4'd0 || buzzer_o !== 1'b0 || wrap_o !== 1'b0 || rom_en_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_mid_note addr=%0d buz=%b wrap=%b en=%b want addr=0 buz=0 wrap=0 en=1",
               rom_addr_o, buzzer_o, wrap_o, rom_en_o);
    end
    cyc();
    cyc();
    checks++;
    if (playing_o !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_replay ply=%b pending=%0d want ply=1 pending=0", playing_o, exp_q.size());
    end
  endtask

  task automatic test_empty_song();
    int en_n, ply_n, lat;
    rom[0] = 12'h000;
    park_idle();
    exp_q.push_back('{addr: 4'd0, wrap: 1'b0});
    sb_on  = 1'b1;
    play_i = 1'b1;
    en_n   = 0;
    ply_n  = 0;
    for (int i = 0; i < 40; i++) begin
      play_i = !(i >= 20 && i < 23);
      cyc();
      if (rom_en_o === 1'b1) en_n++;
      if (playing_o === 1'b1) ply_n++;
    end
    checks++;
    if (en_n != 1 || ply_n != 0) begin
      errors++;
      $display("FAIL empty_song_lockout fetches=%0d play_cycles=%0d want 1 and 0", en_n, ply_n);
    end
    rom[0] = 12'h101;
    exp_q.push_back('{addr: 4'd0, wrap: 1'b0});
    pulse_restart();
    wait_play(20, lat);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL empty_song_resume timeout want playing");
    end
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rom_en_o, rom_addr_o, buzzer_o, playing_o, wrap_o} !== '0) begin
      errors++;
      $display("FAIL async_reset got en=%b addr=%0d buz=%b ply=%b wrap=%b want all 0",
               rom_en_o, rom_addr_o, buzzer_o, playing_o, wrap_o);
    end
    sb_on = 1'b0;
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sb_on  = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
    test_reset();
    test_basic_note();
    test_rest();
    test_pause();
    test_full_wrap();
    test_restart();
    test_empty_song();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bgm_sequencer.md
# bgm_sequencer

Plays background music out of the buzzer block ROM. Drives the ROM's enable and address, decodes each 12-bit note word into a pitch and a duration, and produces the square wave on the buzzer pin. It sits directly downstream of the ROM and directly upstream of the buzzer output. The song loops forever until paused or restarted.

## Interface
- ADDR_WIDTH, 16: ROM address width; must match the ROM instance.
- DATA_WIDTH, 12: ROM word width; fixed at 12 for this note format.
- TICK_DIV, 500: clk cycles per tone tick (10 µs at 50 MHz); ≥1.
- BEAT_DIV, 12_500_000: clk cycles per beat (250 ms at 50 MHz); ≥1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- play_i  in  1  level; high = play, low = pause.
- restart_i  in  1  single-cycle pulse; restart song from address 0.
- rom_en_o  out  ADDR_WIDTH-independent 1  ROM read enable.
- rom_addr_o  out  ADDR_WIDTH  ROM read address.
- rom_data_i  in  DATA_WIDTH  ROM read data; valid the cycle after rom_en_o.
- buzzer_o  out  1  square-wave drive to the buzzer.
- playing_o  out  1  high while a note or rest is sounding (PLAY state, not paused).
- wrap_o  out  1  one-cycle pulse when the song loops back to address 0.

## Operation
- Note word: [11:8] beats (1..15; 0 = end-of-song marker). [7:0] pitch half-period in tone ticks; 0 = rest.
- FSM states: IDLE, FETCH, LATCH, PLAY.
  - IDLE: rom_en_o=0. When play_i=1, go to FETCH.
  - FETCH: rom_en_o=1 for exactly this cycle, with rom_addr_o = current address. Go to LATCH.
  - LATCH: capture rom_data_i.
    - If beats≠0: load the note and go to PLAY.
    - If beats=0 and address≠0: address←0, pulse wrap_o, go to FETCH.
    - If beats=0 and address=0 (empty song): go to IDLE and stay there until restart_i. play_i alone does not leave IDLE in this case.
  - PLAY: runs for beats×BEAT_DIV unpaused cycles. Then address←address+1 and go to FETCH.
    - Address 2^ADDR_WIDTH−1 increments to 0 and pulses wrap_o.
- Tone generation: a prescaler produces one tick every TICK_DIV cycles. A half-period counter toggles buzzer_o every pitch ticks. Both counters are cleared and buzzer_o is forced to 0 at note start. Rest: buzzer_o held at 0.
- Pause: play_i=0 in PLAY freezes the beat, prescaler and half-period counters and forces buzzer_o=0. The note resumes exactly where it stopped when play_i returns to 1.
  - play_i=0 in FETCH or LATCH: the fetch completes, then the block holds in PLAY paused.
  - play_i=0 in IDLE: stays in IDLE.
- restart_i has highest priority in every state:
  - Address←0, all counters cleared, buzzer_o=0.
  - Next state is FETCH if play_i=1, else IDLE.
  - wrap_o is not pulsed.
  - This also clears the empty-song lockout.
- Arithmetic:
  - Beat counter width: clog2(BEAT_DIV)+4.
  - Note length is beats×BEAT_DIV exactly, with no off-by-one.
  - The half-period is exactly pitch×TICK_DIV cycles.

## Timing
- Reset values: rom_en_o=0, rom_addr_o=0, buzzer_o=0, playing_o=0, wrap_o=0. State = IDLE, all counters 0.
- ROM read latency is 1 cycle: data is sampled in LATCH, one cycle after FETCH.
- There is a 2-cycle silent gap (FETCH, LATCH) between consecutive notes; buzzer_o=0 and playing_o=0 during the gap.
- First note after play_i rises from IDLE: PLAY entered 3 cycles after play_i is sampled high.
- wrap_o is asserted in the same cycle as the address change to 0.
- A reset assertion mid-note takes effect immediately and asynchronously; all outputs go to their reset values.

## Test plan
Bench parameters: ADDR_WIDTH=4, TICK_DIV=2, BEAT_DIV=20 unless stated otherwise.

- Basic note: ROM[0]=0x203, ROM[1]=0x000, play_i=1 → rom_en_o pulse with addr 0.
  - PLAY lasts 40 cycles.
  - buzzer_o toggles every 6 cycles (period 12).
  - Then FETCH addr 1, wrap_o pulse, FETCH addr 0.
- Rest: ROM[0]=0x100 → 20 cycles in PLAY with playing_o=1 and buzzer_o=0 throughout.
- Pause: drop play_i for 15 cycles at cycle 10 of the 40-cycle note.
  - buzzer_o=0 while paused.
  - Note ends at cycle 55 after note start.
  - Waveform phase continues from where it stopped.
- Full-ROM wrap: all 16 words = 0x101 → address sequence 0..15,0, with a wrap_o pulse on the 15→0 transition only.
- Restart mid-note at address 5 → rom_addr_o=0 the next cycle and buzzer_o=0. No wrap_o pulse. FETCH of address 0 follows.
- Empty song: ROM[0]=0x000 → block stays in IDLE with play_i=1.
  - Reload ROM[0]=0x101 and pulse restart_i → playback resumes.
  - Async reset mid-PLAY → all outputs 0 immediately.
